// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer.
// Element indices are row-major and IDX_W bits wide.
package matmul_pkg;

    localparam int IDX_W = 4;
    localparam int N_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mm_state_t;

    function automatic logic [IDX_W-1:0] flat_idx(
        input logic [IDX_W-1:0] r,
        input logic [IDX_W-1:0] c,
        input int               n
    );
        return IDX_W'(int'(r) * n + int'(c));
    endfunction

endpackage

// File: rtl/mm_loop_counter.sv
// Nested i/j/k loop counters for the matmul sequencer.
// k runs fastest and i is outermost; all wrap to zero after the last step.
module mm_loop_counter
    import matmul_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] k,
    output logic             k_last,
    output logic             last
);

    localparam logic [IDX_W-1:0] NM1 = IDX_W'(N - 1);

    logic j_last;
    logic i_last;

    assign k_last = (k == NM1);
    assign j_last = (j == NM1);
    assign i_last = (i == NM1);
    assign last   = i_last && j_last && k_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (adv) begin
            unique case (1'b1)
                !k_last: begin
                    k <= k + 1'b1;
                end
                k_last && !j_last: begin
                    k <= '0;
                    j <= j + 1'b1;
                end
                k_last && j_last && !i_last: begin
                    k <= '0;
                    j <= '0;
                    i <= i + 1'b1;
                end
                default: begin
                    i <= '0;
                    j <= '0;
                    k <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer issuing MAC operand indices for C = A*B, with a
// MAC_LAT-deep write-back delay line and a stall that freezes everything.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic [IDX_W-1:0] a_idx,
    output logic [IDX_W-1:0] b_idx,
    output logic             mac_en,
    output logic             mac_clr,
    output logic             c_wr,
    output logic [IDX_W-1:0] c_idx,
    output logic             busy,
    output logic             done
);

    mm_state_t        state;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] k;
    logic             k_last;
    logic             last;
    logic             issue;
    logic             wb_in;
    logic             more;

    logic [MAC_LAT-1:0] dl_v;
    logic [IDX_W-1:0]   dl_idx [MAC_LAT];

    assign issue = (state == RUN) && !stall;
    assign wb_in = issue && k_last;

    mm_loop_counter #(
        .N(N)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == IDLE),
        .adv    (issue),
        .i      (i),
        .j      (j),
        .k      (k),
        .k_last (k_last),
        .last   (last)
    );

    // Entries still in flight once the oldest one has been written.
    always_comb begin
        more = 1'b0;
        for (int m = 0; m < MAC_LAT - 1; m++) begin
            more = more | dl_v[m];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dl_v  <= '0;
            for (int m = 0; m < MAC_LAT; m++) begin
                dl_idx[m] <= '0;
            end
        end else if (!stall) begin
            dl_v[0]   <= wb_in;
            dl_idx[0] <= wb_in ? flat_idx(i, j, N) : '0;
            for (int m = 1; m < MAC_LAT; m++) begin
                dl_v[m]   <= dl_v[m-1];
                dl_idx[m] <= dl_idx[m-1];
            end
            unique case (state)
                IDLE:  if (start) state <= RUN;
                RUN:   if (last) state <= DRAIN;
                DRAIN: if (!more) state <= DONE;
                DONE:  state <= IDLE;
            endcase
        end
    end

    assign mac_en  = issue;
    assign mac_clr = issue && (k == '0);
    assign a_idx   = flat_idx(i, k, N);
    assign b_idx   = flat_idx(k, j, N);
    assign c_idx   = dl_idx[MAC_LAT-1];
    assign c_wr    = dl_v[MAC_LAT-1] && !stall;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: N=3/LAT=1 and N=2/LAT=3 instances side by side,
// checked by spot vectors, an event-level timing model and a MAC model.
module tb_matmul_sequencer;

    localparam int T_MAX = 100;

    typedef struct {
        logic       mac_en;
        logic       mac_clr;
        logic       c_wr;
        logic       busy;
        logic       done;
        logic [3:0] a_idx;
        logic [3:0] b_idx;
        logic [3:0] c_idx;
    } obs_t;

    typedef struct {
        int         scen;
        int         d;
        int         cyc;
        logic       en;
        logic       clr;
        logic [3:0] a;
        logic [3:0] b;
        logic       wr;
        logic [3:0] ci;
        logic       busy;
        logic       done;
        bit         ab;
        bit         cc;
    } vec_t;

    logic clk;
    logic rst;
    logic start;
    logic stall;

    logic [3:0] a3, b3, ci3, a2, b2, ci2;
    logic en3, clr3, wr3, busy3, done3;
    logic en2, clr2, wr2, busy2, done2;

    int checks;
    int failures;

    int   dn [2] = '{3, 2};
    int   dml[2] = '{1, 3};
    obs_t tr [2][T_MAX];
    obs_t ex [2][T_MAX];
    bit   abv[2][T_MAX];
    bit   st [T_MAX];
    bit   sl [T_MAX];
    bit   rs [T_MAX];

    int A   [2][16];
    int B   [2][16];
    int Cm  [2][16];
    int pipe[2][4];
    int acc [2];
    int wrn [2];

    vec_t vt[$];

    matmul_sequencer #(.N(3), .MAC_LAT(1)) dut3 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .a_idx(a3), .b_idx(b3), .mac_en(en3), .mac_clr(clr3),
        .c_wr(wr3), .c_idx(ci3), .busy(busy3), .done(done3)
    );

    matmul_sequencer #(.N(2), .MAC_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .a_idx(a2), .b_idx(b2), .mac_en(en2), .mac_clr(clr2),
        .c_wr(wr2), .c_idx(ci2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(int scen, int d, int cyc, bit en, bit clr,
                                int a, int b, bit wr, int ci, bit bz,
                                bit dn_, bit ab, bit cc);
        vec_t v;
        v.scen = scen; v.d = d; v.cyc = cyc;
        v.en = en; v.clr = clr; v.a = 4'(a); v.b = 4'(b);
        v.wr = wr; v.ci = 4'(ci); v.busy = bz; v.done = dn_;
        v.ab = ab; v.cc = cc;
        return v;
    endfunction

    task automatic clr_pat();
        for (int c = 0; c < T_MAX; c++) begin
            st[c] = 1'b0; sl[c] = 1'b0; rs[c] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_mats();
        for (int d = 0; d < 2; d++) begin
            for (int x = 0; x < 16; x++) begin
                A[d][x] = int'($urandom_range(255));
                B[d][x] = int'($urandom_range(255));
            end
        end
    endtask

    // Behavioural MAC with a MAC_LAT-deep result pipe, advanced on live cycles.
    task automatic mac_step(input int d, input obs_t o);
        if (o.c_wr) begin
            Cm[d][o.c_idx] = pipe[d][dml[d]-1];
            wrn[d]++;
        end
        if (o.mac_en) begin
            acc[d] = (o.mac_clr ? 0 : acc[d]) + A[d][o.a_idx] * B[d][o.b_idx];
        end
        for (int m = 3; m > 0; m--) pipe[d][m] = pipe[d][m-1];
        pipe[d][0] = acc[d];
    endtask

    task automatic run_seq(input int T);
        for (int d = 0; d < 2; d++) begin
            acc[d] = 0; wrn[d] = 0;
            for (int m = 0; m < 4; m++) pipe[d][m] = 0;
            for (int x = 0; x < 16; x++) Cm[d][x] = -1;
        end
        for (int c = 0; c < T; c++) begin
            @(negedge clk);
            start = st[c]; stall = sl[c]; rst = rs[c];
            #1;
            tr[0][c].mac_en = en3; tr[0][c].mac_clr = clr3;
            tr[0][c].c_wr = wr3;   tr[0][c].busy = busy3;
            tr[0][c].done = done3; tr[0][c].a_idx = a3;
            tr[0][c].b_idx = b3;   tr[0][c].c_idx = ci3;
            tr[1][c].mac_en = en2; tr[1][c].mac_clr = clr2;
            tr[1][c].c_wr = wr2;   tr[1][c].busy = busy2;
            tr[1][c].done = done2; tr[1][c].a_idx = a2;
            tr[1][c].b_idx = b2;   tr[1][c].c_idx = ci2;
            if (!stall && !rst) begin
                mac_step(0, tr[0][c]);
                mac_step(1, tr[1][c]);
            end
        end
    endtask

    // Expected trace for one run started at cycle 0, built from the issue order
    // and the "MAC_LAT live cycles later" write rule.
    task automatic build_exp(input int d);
        int n, ml, c, w, cnt, last_wr, dd;
        n = dn[d]; ml = dml[d];
        for (int t = 0; t < T_MAX; t++) begin
            ex[d][t] = '{default: '0};
            abv[d][t] = 1'b0;
        end
        c = 1; last_wr = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                for (int k = 0; k < n; k++) begin
                    while (sl[c] && c < T_MAX - 1) begin
                        ex[d][c].busy = 1'b1;
                        ex[d][c].a_idx = 4'(i * n + k);
                        ex[d][c].b_idx = 4'(k * n + j);
                        abv[d][c] = 1'b1;
                        c++;
                    end
                    ex[d][c].busy = 1'b1;
                    ex[d][c].mac_en = 1'b1;
                    ex[d][c].mac_clr = (k == 0);
                    ex[d][c].a_idx = 4'(i * n + k);
                    ex[d][c].b_idx = 4'(k * n + j);
                    abv[d][c] = 1'b1;
                    if (k == n - 1) begin
                        w = c; cnt = 0;
                        while (cnt < ml && w < T_MAX - 1) begin
                            w++;
                            if (!sl[w]) cnt++;
                        end
                        ex[d][w].c_wr = 1'b1;
                        ex[d][w].c_idx = 4'(i * n + j);
                        last_wr = w;
                    end
                    if (c < T_MAX - 1) c++;
                end
        for (int t = c; t <= last_wr; t++) ex[d][t].busy = 1'b1;
        dd = last_wr + 1;
        while (sl[dd] && dd < T_MAX - 1) begin
            ex[d][dd].busy = 1'b1; ex[d][dd].done = 1'b1;
            dd++;
        end
        ex[d][dd].busy = 1'b1; ex[d][dd].done = 1'b1;
    endtask

    task automatic check_model(input int d, input int T, input string tag);
        obs_t o, e;
        bit bad;
        for (int c = 0; c < T; c++) begin
            o = tr[d][c]; e = ex[d][c];
            bad = (o.mac_en !== e.mac_en) || (o.mac_clr !== e.mac_clr) ||
                  (o.c_wr !== e.c_wr) || (o.busy !== e.busy) ||
                  (o.done !== e.done);
            if (abv[d][c] && (o.a_idx !== e.a_idx || o.b_idx !== e.b_idx))
                bad = 1'b1;
            if (e.c_wr && o.c_idx !== e.c_idx) bad = 1'b1;
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s dut%0d cyc%0d got en=%b clr=%b a=%0d b=%0d wr=%b ci=%0d busy=%b done=%b want en=%b clr=%b a=%0d b=%0d wr=%b ci=%0d busy=%b done=%b",
                         tag, d, c, o.mac_en, o.mac_clr, o.a_idx, o.b_idx,
                         o.c_wr, o.c_idx, o.busy, o.done, e.mac_en, e.mac_clr,
                         e.a_idx, e.b_idx, e.c_wr, e.c_idx, e.busy, e.done);
            end
        end
    endtask

    task automatic check_c(input int d, input string tag);
        int n, g;
        n = dn[d];
        checks++;
        if (wrn[d] != n * n) begin
            failures++;
            $display("FAIL %s dut%0d c_wr count got %0d want %0d", tag, d, wrn[d], n * n);
        end
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                g = 0;
                for (int k = 0; k < n; k++) g += A[d][i*n+k] * B[d][k*n+j];
                checks++;
                if (Cm[d][i*n+j] != g) begin
                    failures++;
                    $display("FAIL %s dut%0d C[%0d][%0d] got %0d want %0d",
                             tag, d, i, j, Cm[d][i*n+j], g);
                end
            end
    endtask

    task automatic check_table(input int scen);
        obs_t o;
        bit bad;
        foreach (vt[x]) begin
            if (vt[x].scen == scen) begin
                o = tr[vt[x].d][vt[x].cyc];
                bad = (o.mac_en !== vt[x].en) || (o.mac_clr !== vt[x].clr) ||
                      (o.c_wr !== vt[x].wr) || (o.busy !== vt[x].busy) ||
                      (o.done !== vt[x].done);
                if (vt[x].ab && (o.a_idx !== vt[x].a || o.b_idx !== vt[x].b))
                    bad = 1'b1;
                if (vt[x].cc && o.c_idx !== vt[x].ci) bad = 1'b1;
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL vec s%0d dut%0d cyc%0d got en=%b clr=%b a=%0d b=%0d wr=%b ci=%0d busy=%b done=%b want en=%b clr=%b a=%0d b=%0d wr=%b ci=%0d busy=%b done=%b",
                             scen, vt[x].d, vt[x].cyc, o.mac_en, o.mac_clr,
                             o.a_idx, o.b_idx, o.c_wr, o.c_idx, o.busy, o.done,
                             vt[x].en, vt[x].clr, vt[x].a, vt[x].b, vt[x].wr,
                             vt[x].ci, vt[x].busy, vt[x].done);
                end
            end
        end
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got %b want %b", tag, got, want);
        end
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    initial begin
        int ens;
        bool_dummy: begin end
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b1; stall = 1'b1;

        // scen 0: no stall
        vt.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 1,  1, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 2,  1, 0, 1, 3, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 3,  1, 0, 2, 6, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 4,  1, 1, 0, 1, 1, 0, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 7,  1, 1, 0, 2, 1, 1, 1, 0, 1, 1));
        vt.push_back(mk(0, 0, 27, 1, 0, 8, 8, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 28, 0, 0, 0, 0, 1, 8, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 29, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        vt.push_back(mk(0, 1, 1,  1, 1, 0, 0, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 2,  1, 0, 1, 2, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 3,  1, 1, 0, 1, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 5,  1, 1, 2, 0, 1, 0, 1, 0, 1, 1));
        vt.push_back(mk(0, 1, 8,  1, 0, 3, 3, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(0, 1, 9,  0, 0, 0, 0, 1, 2, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 11, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1));
        vt.push_back(mk(0, 1, 12, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(0, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // scen 1: stall in cycles 10..14
        vt.push_back(mk(1, 0, 9,  1, 0, 2, 8, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(1, 0, 10, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(1, 0, 14, 0, 0, 3, 0, 0, 0, 1, 0, 1, 0));
        vt.push_back(mk(1, 0, 15, 1, 1, 3, 0, 1, 2, 1, 0, 1, 1));
        vt.push_back(mk(1, 0, 33, 0, 0, 0, 0, 1, 8, 1, 0, 0, 1));
        vt.push_back(mk(1, 0, 34, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 0, 35, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vt.push_back(mk(1, 1, 11, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vt.push_back(mk(1, 1, 16, 0, 0, 0, 0, 1, 3, 1, 0, 0, 1));
        vt.push_back(mk(1, 1, 17, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 1, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset with start and stall high
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; stall = 1'b0;
        #1;
        expect_int("reset dut3 outputs",
                   int'({a3, b3, ci3, en3, clr3, wr3, busy3, done3}), 0);
        expect_int("reset dut2 outputs",
                   int'({a2, b2, ci2, en2, clr2, wr2, busy2, done2}), 0);

        // Plain run
        clr_pat(); st[0] = 1'b1; rand_mats();
        run_seq(40);
        check_table(0);
        for (int d = 0; d < 2; d++) begin
            build_exp(d); check_model(d, 40, "nostall"); check_c(d, "nostall");
        end
        do_reset();

        // Five-cycle stall from issue cycle 10
        clr_pat(); st[0] = 1'b1;
        for (int c = 10; c < 15; c++) sl[c] = 1'b1;
        rand_mats();
        run_seq(45);
        check_table(1);
        for (int d = 0; d < 2; d++) begin
            build_exp(d); check_model(d, 45, "stall5"); check_c(d, "stall5");
        end
        do_reset();

        // Reset mid-run, overriding stall and start
        clr_pat(); st[0] = 1'b1;
        rs[15] = 1'b1; sl[15] = 1'b1; st[15] = 1'b1;
        run_seq(50);
        expect_int("midrst dut3 cyc16 outputs",
                   int'({tr[0][16].a_idx, tr[0][16].b_idx, tr[0][16].c_idx,
                         tr[0][16].mac_en, tr[0][16].mac_clr, tr[0][16].c_wr,
                         tr[0][16].busy, tr[0][16].done}), 0);
        ens = 0;
        for (int c = 16; c < 50; c++)
            for (int d = 0; d < 2; d++)
                if (tr[d][c].c_wr || tr[d][c].busy || tr[d][c].mac_en) ens++;
        expect_int("midrst activity after reset", ens, 0);
        do_reset();

        // Fresh start after the mid-run reset
        clr_pat(); st[0] = 1'b1; rand_mats();
        run_seq(40);
        for (int d = 0; d < 2; d++) begin
            build_exp(d); check_model(d, 40, "postrst"); check_c(d, "postrst");
        end
        do_reset();

        // start held high: done, one IDLE cycle, then the next run
        clr_pat();
        for (int c = 0; c < T_MAX; c++) st[c] = 1'b1;
        run_seq(40);
        expect_bit("held dut3 done@29", tr[0][29].done, 1'b1);
        expect_bit("held dut3 done@30", tr[0][30].done, 1'b0);
        expect_bit("held dut3 busy@30", tr[0][30].busy, 1'b0);
        expect_bit("held dut3 restart@31",
                   tr[0][31].mac_en && tr[0][31].mac_clr &&
                   tr[0][31].a_idx == 4'd0 && tr[0][31].b_idx == 4'd0, 1'b1);
        expect_bit("held dut2 done@12", tr[1][12].done, 1'b1);
        expect_bit("held dut2 busy@13", tr[1][13].busy, 1'b0);
        expect_bit("held dut2 restart@14", tr[1][14].mac_en && tr[1][14].mac_clr, 1'b1);
        ens = 0;
        for (int c = 0; c <= 30; c++) if (tr[0][c].mac_en) ens++;
        expect_int("held dut3 issues before restart", ens, 27);
        ens = 0;
        for (int c = 0; c <= 13; c++) if (tr[1][c].mac_en) ens++;
        expect_int("held dut2 issues before restart", ens, 8);
        do_reset();

        // Random stall patterns and random matrices
        for (int r = 0; r < 5; r++) begin
            clr_pat(); st[0] = 1'b1;
            for (int c = 1; c < 50; c++) sl[c] = ($urandom_range(3) == 0);
            rand_mats();
            run_seq(T_MAX);
            for (int d = 0; d < 2; d++) begin
                build_exp(d); check_model(d, T_MAX, "rand"); check_c(d, "rand");
            end
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the square matrix dimension; legal values are 2..4.
REQ-002 The block SHALL have parameter MAC_LAT, default 1, meaning the number of cycles from a MAC issue to a valid accumulator output; legal values are 1..4.
REQ-003 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request to compute C=A*B; sampled only in IDLE.
REQ-007 stall  input  1  freezes all sequencing while high.
REQ-008 a_idx  output  4  A operand element index, row-major, equal to i*N+k.
REQ-009 b_idx  output  4  B operand element index, row-major, equal to k*N+j.
REQ-010 mac_en  output  1  MAC accumulate strobe.
REQ-011 mac_clr  output  1  when high with mac_en, the MAC loads the product instead of accumulating.
REQ-012 c_wr  output  1  result write strobe.
REQ-013 c_idx  output  4  result element index, equal to i*N+j.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-017 IDLE SHALL go to RUN on the edge where start=1; i, j and k SHALL be 0 on entry to RUN.
REQ-018 In RUN with stall=0, each cycle SHALL issue one MAC with mac_en=1 and mac_clr=(k==0), then advance the loop order: k fastest, then j, then i (i outermost).
REQ-019 RUN SHALL go to DRAIN after issuing (i,j,k)=(N-1,N-1,N-1), i.e. after exactly N*N*N issue cycles.
REQ-020 When the k==N-1 MAC is issued, (i*N+j) SHALL enter a MAC_LAT-deep write-back delay line; c_wr SHALL pulse with that c_idx exactly MAC_LAT non-stalled cycles later.
REQ-021 DRAIN SHALL go to DONE in the cycle after the last c_wr; DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-022 While stall=1 the block SHALL hold the FSM state, the loop counters and the delay line; mac_en and c_wr SHALL be 0; a_idx, b_idx and c_idx SHALL hold their values; a stalled DONE cycle SHALL keep done high.
REQ-023 start SHALL be ignored outside IDLE; there is no abort.
REQ-024 Outside RUN, mac_en and mac_clr SHALL be 0; c_wr SHALL be high only when a valid delay-line entry emerges.
REQ-025 A start asserted in the same cycle done is high SHALL be ignored; a new run requires start sampled in IDLE.
REQ-026 For N=3 and MAC_LAT=1 with no stall, latency SHALL be: start sampled at edge 0, issues in cycles 1..27, c_wr in cycles 4,7,...,28, done in cycle 29.
REQ-027 Index arithmetic SHALL be 4-bit unsigned; indices SHALL never exceed N*N-1.

Reset
REQ-028 Reset SHALL apply on any edge where rst=1, including mid-run, and SHALL override stall and start.
REQ-029 After reset: state=IDLE; i=j=k=0; the delay line SHALL be empty; a_idx=b_idx=c_idx=0; mac_en=mac_clr=c_wr=busy=done=0.
REQ-030 Reset mid-RUN or mid-DRAIN SHALL suppress all pending c_wr pulses.

Structure
REQ-031 A shared package matmul_pkg SHALL hold the state type (IDLE/RUN/DRAIN/DONE), IDX_W=4 and default N.
REQ-032 One sub-module, mm_loop_counter, SHALL implement the nested i/j/k counters with advance-enable and a last-iteration flag; the FSM and the delay line SHALL stay in matmul_sequencer.

Verification
REQ-033 Defaults, start pulse, stall=0 -> 27 mac_en cycles; first issue a_idx=0, b_idx=0, mac_clr=1; c_wr sequence c_idx=0..8 in cycles 4,7,...,28; done in cycle 29 only.
REQ-034 stall=1 for 5 cycles starting at issue cycle 10 -> outputs frozen, mac_en=0; index sequence otherwise identical; done in cycle 34.
REQ-035 rst=1 at cycle 15 -> next cycle busy=0 and all outputs 0; no c_wr afterwards; a new start gives the full REQ-033 sequence.
REQ-036 start held high continuously -> runs back-to-back with exactly one IDLE cycle between done and the next RUN; start ignored during busy.
REQ-037 N=2, MAC_LAT=3 -> 8 issues; c_wr c_idx=0,1,2,3 at cycles 5,7,9,11; done at cycle 12.
REQ-038 A bench reference model of the MAC fed by a_idx/b_idx SHALL match the golden C=A*B on random 8-bit matrices.
